inst_prefetch_buffer: RTL and testbench
=======================================

Name: inst_prefetch_buffer

Overview:
Parametrised instruction prefetch queue between instruction memory and the decode stage. It replaces the single-entry fetch register of the current 5-stage core. The block issues several in-order fetch requests ahead of decode, buffers the returned instructions with their PCs, and tolerates variable memory latency and decode back-pressure (bubble). On a misprediction flush it redirects to the correct PC and discards in-flight responses.

Parameters:
size, 32, address/instruction width in bits
DEPTH, 4, instruction buffer entries (power of two, >=2)
MAX_OUTSTANDING, 2, max in-flight memory requests (>=1, <=DEPTH)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush_i  in  1  redirect request from execute (misprediction)
flush_pc_i  in  size  redirect target (correct_pc)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  size  fetch address
imem_ready_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid, in request order
imem_rdata_i  in  size  response instruction
inst_valid_o  out  1  buffer head valid toward decode
inst_o  out  size  head instruction
pc_o  out  size  head PC
inst_ready_i  in  1  decode consumes head (driven as !buble)
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC; buffer, tag FIFO, outstanding, discard_cnt = 0. Outputs: imem_req_o=0, inst_valid_o=0, count_o=0, imem_addr_o=RESET_PC, inst_o=0, pc_o=0.
- Issue: imem_req_o = !flush_i && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH. imem_addr_o = fetch_pc.
- A request is accepted when imem_req_o && imem_ready_i. On acceptance: push fetch_pc to the PC tag FIFO, outstanding+1, fetch_pc += 4 (wraps modulo 2^size).
- The credit rule guarantees that every accepted response has a buffer slot. Push-on-full cannot occur and is an assertion failure.
- Response handling (imem_rvalid_i): outstanding-1 and pop the tag.
  - If discard_cnt>0: drop the response, discard_cnt-1.
  - Otherwise: push {tag_pc, imem_rdata_i} to the buffer.
- Response latency: a response accepted at edge N is visible at inst_o/pc_o after that edge (1 cycle), provided the buffer was empty.
- Output: inst_valid_o = count!=0. The head pops on inst_valid_o && inst_ready_i. Push and pop in the same cycle are both legal; count is unchanged.
- Flush (flush_i=1), at the edge:
  - buffer and tag FIFO cleared, count=0
  - fetch_pc = {flush_pc_i[size-1:2],2'b00}
  - discard_cnt = outstanding - (imem_rvalid_i?1:0); this already includes any prior discard_cnt
  - outstanding keeps its accounting; a response arriving in the flush cycle is dropped
  - a pop in the flush cycle is ignored
  - no request is issued in the flush cycle; the first redirected request is issued in the next cycle
- inst_valid_o stays asserted during the flush cycle if the buffer is non-empty. Decode must squash it; the core already flushes decode on misprediction.
- Back-to-back flushes: each recomputes discard_cnt from outstanding. The last target wins.
- imem_rvalid_i with outstanding==0: ignored, state unchanged, assertion fires.
- Ordering: memory returns responses strictly in request order. The block never reorders.
- Sustained throughput: 1 instr/cycle when imem_ready_i=1, single-cycle memory latency, and MAX_OUTSTANDING>=2.

Decomposition:
- Package prefetch_pkg:
  - typedef fetch_entry_t {pc, instr} (parametrised through size)
  - localparam INSTR_BYTES=4
  - function clog2-safe count width
- Sub-module sync_fifo (WIDTH, DEPTH): circular buffer with wrap-extended pointers, clear input, count output. Instantiated twice: the instruction buffer (DEPTH, fetch_entry_t) and the PC tag FIFO (MAX_OUTSTANDING, size).
- Top-level logic: credit/issue logic, fetch_pc, outstanding and discard counters.

Test Plan:
- Reset release, imem_ready_i=1, 1-cycle response latency, inst_ready_i=1 -> addresses 0x0,0x4,0x8..., inst_o/pc_o stream 1/cycle with correct PC pairing.
- inst_ready_i=0 held, DEPTH=4 -> exactly 4 accepted requests, imem_req_o drops, count_o=4. Release inst_ready_i -> in-order drain, fetch resumes at 0x10.
- 3-cycle response latency, MAX_OUTSTANDING=2 -> never more than 2 unanswered requests, no lost or duplicated instructions.
- Two requests in flight (0x20,0x24), flush_i with flush_pc_i=0x103 -> both late responses dropped, next request 0x100, first inst_o has pc_o=0x100.
- Flush coincident with a response and a pop -> response dropped, discard_cnt=outstanding-1, count_o=0 next cycle.
- Assert reset mid-stream with 2 outstanding, then release -> all state cleared, fetch restarts at RESET_PC, stale responses after release trip the outstanding==0 assertion path and are ignored.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
// Entry layout and count-width helper used by the fetch front end.
package prefetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one extra bit to represent "full"
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_prefetch_buffer_sync_fifo.sv
// Circular FIFO with wrap-extended pointers, synchronous clear
// and occupancy count; read data is the combinational head.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A pop frees the slot in the same cycle, so push-while-full is fine then
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: credit-based in-order fetch issue,
// PC tagging of responses, and flush redirect with response discard.
module inst_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int               size            = XLEN,
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [size-1:0]  RESET_PC        = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [size-1:0]             flush_pc_i,
    output logic                        imem_req_o,
    output logic [size-1:0]             imem_addr_o,
    input  logic                        imem_ready_i,
    input  logic                        imem_rvalid_i,
    input  logic [size-1:0]             imem_rdata_i,
    output logic                        inst_valid_o,
    output logic [size-1:0]             inst_o,
    output logic [size-1:0]             pc_o,
    input  logic                        inst_ready_i,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int CW = cnt_width(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = ((MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1) + 1;
    localparam logic [size-1:0] ALIGN_MASK = ~(size'(INSTR_BYTES - 1));

    typedef struct packed {
        logic [size-1:0] pc;
        logic [size-1:0] instr;
    } entry_t;

    logic [size-1:0] fetch_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [TW-1:0]   tag_count;
    logic [size-1:0] tag_pc;
    entry_t          head;
    entry_t          wentry;
    logic            accept;
    logic            rsp;
    logic            tag_pop;
    logic            tag_full;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_full;

    // Credits: in-flight plus buffered never exceeds buffer capacity
    assign imem_req_o = reset && !flush_i
                     && (int'(outstanding) < MAX_OUTSTANDING)
                     && (int'(count) + int'(outstanding) < DEPTH);

    assign accept   = imem_req_o && imem_ready_i;
    assign rsp      = imem_rvalid_i && (outstanding != '0);
    assign tag_pop  = rsp && (discard == '0);
    assign buf_push = tag_pop && !flush_i;
    assign buf_pop  = inst_valid_o && inst_ready_i && !flush_i;
    assign wentry   = {tag_pc, imem_rdata_i};

    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = (count != '0);
    assign inst_o       = head.instr;
    assign pc_o         = head.pc;
    assign count_o      = count;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .push  (buf_push),
        .pop   (buf_pop),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .full  (buf_full)
    );

    sync_fifo #(
        .WIDTH (size),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .push  (accept),
        .pop   (tag_pop),
        .wdata (fetch_pc),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(rsp);
            if (flush_i) begin
                fetch_pc <= flush_pc_i & ALIGN_MASK;
                discard  <= outstanding - OW'(rsp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + size'(INSTR_BYTES);
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (!(buf_push && buf_full && !buf_pop));
            assert (!(accept && tag_full));
            assert (!(imem_rvalid_i && (outstanding == '0)));
            assert (!(tag_pop && (tag_count == '0)));
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer with an in-order
// variable-latency memory model driven cycle by cycle.
module tb_inst_prefetch_buffer;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i;
    logic [2:0]  count_o;

    inst_prefetch_buffer #(
        .size            (32),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i),
        .count_o       (count_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];
    ent_t        sb[$];
    logic [31:0] exp_pc;
    logic [31:0] last_acc;
    logic [31:0] last_pop_pc;
    int          cyc;
    int          lat;
    int          rdy_pct;
    int          ird_pct;
    int          n_acc;
    int          n_pop;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, observe, then cross posedge
    task automatic step(input bit fl, input logic [31:0] fpc);
        bit   rsp;
        bit   acc;
        bit   exp_req;
        req_t r;
        flush_i      = fl;
        flush_pc_i   = fpc;
        imem_ready_i = ($urandom_range(99) < rdy_pct);
        inst_ready_i = ($urandom_range(99) < ird_pct);
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? mem_data(pend[0].addr) : $urandom();
        #1;
        check_eq("count", count_o, sb.size());
        check_eq("valid", inst_valid_o, sb.size() != 0);
        check_eq("max_out", pend.size() <= MAX_OUT, 1);
        exp_req = !fl && (pend.size() < MAX_OUT)
               && (sb.size() + pend.size() < DEPTH);
        check_eq("req", imem_req_o, exp_req);
        if (inst_valid_o && inst_ready_i && !fl && sb.size() != 0) begin
            check_eq("pop_pc", pc_o, sb[0].pc);
            check_eq("pop_instr", inst_o, sb[0].instr);
            last_pop_pc = pc_o;
            void'(sb.pop_front());
            n_pop++;
        end
        if (rsp) begin
            r = pend.pop_front();
            if (!r.stale && !fl) sb.push_back(ent_t'({r.addr, mem_data(r.addr)}));
        end
        acc = imem_req_o && imem_ready_i;
        if (acc) begin
            check_eq("addr", imem_addr_o, exp_pc);
            pend.push_back('{addr: exp_pc, due: cyc + lat, stale: 1'b0});
            last_acc = exp_pc;
            exp_pc   = exp_pc + 32'd4;
            n_acc++;
        end
        if (fl) begin
            sb.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_pc = {fpc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        flush_i       = 1'b0;
        flush_pc_i    = '0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        imem_ready_i  = 1'b1;
        inst_ready_i  = 1'b1;
        pend.delete();
        sb.delete();
        exp_pc = 32'h0;
        #1;
        check_eq("rst_req", imem_req_o, 0);
        check_eq("rst_valid", inst_valid_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_addr", imem_addr_o, 32'h0);
        check_eq("rst_inst", inst_o, 0);
        check_eq("rst_pc", pc_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int a0;
        int p0;
        bit found;
        checks = 0; failures = 0; cyc = 0;
        n_acc = 0; n_pop = 0; last_acc = '0; last_pop_pc = '0;
        lat = 1; rdy_pct = 100; ird_pct = 100;
        @(negedge clk);

        // streaming at one instruction per cycle
        do_reset();
        repeat (5) step(0, 0);
        p0 = n_pop;
        repeat (20) step(0, 0);
        check_eq("throughput", n_pop - p0, 20);

        // decode stalled: buffer fills, fetch stops, then resumes at 0x10
        do_reset();
        ird_pct = 0;
        a0 = n_acc;
        repeat (10) step(0, 0);
        check_eq("stall_acc", n_acc - a0, 4);
        check_eq("stall_count", count_o, 4);
        check_eq("stall_req", imem_req_o, 0);
        ird_pct = 100;
        a0 = n_acc;
        for (int i = 0; i < 20 && n_acc == a0; i++) step(0, 0);
        check_eq("resume_addr", last_acc, 32'h10);
        repeat (10) step(0, 0);

        // flush with 0x20/0x24 in flight
        do_reset();
        lat = 3;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (exp_pc == 32'h28 && pend.size() == 2 && pend[0].due > cyc) found = 1;
            else step(0, 0);
        end
        check_eq("flush1_setup", found, 1);
        step(1, 32'h103);
        a0 = n_acc;
        for (int i = 0; i < 30 && n_acc == a0; i++) step(0, 0);
        check_eq("redirect_addr", last_acc, 32'h100);
        p0 = n_pop;
        for (int i = 0; i < 30 && n_pop == p0; i++) step(0, 0);
        check_eq("redirect_pc", last_pop_pc, 32'h100);

        // flush coincident with a live response and a head pop
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (pend.size() != 0 && pend[0].due <= cyc && !pend[0].stale && inst_valid_o)
                found = 1;
            else step(0, 0);
        end
        check_eq("flush2_setup", found, 1);
        step(1, 32'h200);
        check_eq("flush2_count", count_o, 0);
        check_eq("flush2_valid", inst_valid_o, 0);
        repeat (20) step(0, 0);

        // random back-pressure, latency and flushes
        for (int l = 2; l <= 4; l++) begin
            lat = l; rdy_pct = 70; ird_pct = 60;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(39) == 0) step(1, $urandom());
                else step(0, 0);
            end
        end

        // reset mid-stream with two requests outstanding
        lat = 3; rdy_pct = 100; ird_pct = 100;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pend.size() == 2) found = 1;
            else step(0, 0);
        end
        check_eq("midrst_setup", found, 1);
        do_reset();
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc == a0; i++) step(0, 0);
        check_eq("restart_addr", last_acc, 32'h0);
        repeat (20) step(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
